// File: rtl/bank_timing_pkg.sv
// Decode offsets, opcodes and shared types for the bank timing tracker.
package bank_timing_pkg;

  localparam int VALID_BIT = 31;
  localparam int RAS_BIT   = 30;
  localparam int CAS_BIT   = 29;
  localparam int WE_BIT    = 28;
  localparam int CS_OFFSET = 24;
  localparam int A10_BIT   = 10;

  // {RAS, CAS, WE} as seen on the instruction word
  localparam logic [2:0] OP_ACT  = 3'b011;
  localparam logic [2:0] OP_PRE  = 3'b010;
  localparam logic [2:0] OP_REF  = 3'b001;
  localparam logic [1:0] OP_RDWR = 2'b10;

  localparam int ROW_W = 15;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ACT    = 2'd1,
    ERR_ACCESS = 2'd2,
    ERR_REF    = 2'd3
  } err_code_e;

  typedef struct packed {
    logic             open;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] rcd;
    logic [CNT_W-1:0] ras;
    logic [CNT_W-1:0] rp;
  } bank_state_t;

endpackage

// File: rtl/bank_timing_if.sv
// Command feed and bank query bus of the bank timing tracker.
interface bank_timing_if #(
  parameter int ROW_WIDTH  = 15,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH   = 1
);
  localparam int RANK_W = (CS_WIDTH > 1) ? $clog2(CS_WIDTH) : 1;

  logic [31:0]           instr;
  logic                  is_app;
  logic                  is_mnt;
  logic [RANK_W-1:0]     q_rank;
  logic [BANK_WIDTH-1:0] q_bank;
  logic [ROW_WIDTH:0]    q_state;
  logic                  q_rdwr_ready;
  logic                  q_pre_ready;
  logic                  q_act_ready;
  logic [CS_WIDTH-1:0]   any_open;
  logic                  err;
  logic [1:0]            err_code;

  modport master (
    output instr, is_app, is_mnt, q_rank, q_bank,
    input  q_state, q_rdwr_ready, q_pre_ready,
    input  q_act_ready, any_open, err, err_code
  );

  modport slave (
    input  instr, is_app, is_mnt, q_rank, q_bank,
    output q_state, q_rdwr_ready, q_pre_ready,
    output q_act_ready, any_open, err, err_code
  );
endinterface

// File: rtl/bank_timing_tracker_bank_timer.sv
// One bank: open bit, last row and saturating tRCD/tRAS/tRP countdowns.
module bank_timer #(
  parameter int ROW_WIDTH = 15,
  parameter int CNT_WIDTH = 6,
  parameter int T_RCD     = 6,
  parameter int T_RAS     = 15,
  parameter int T_RP      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 act,
  input  logic                 pre,
  input  logic [ROW_WIDTH-1:0] row_in,
  output logic                 open,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 rdwr_ready,
  output logic                 pre_ready,
  output logic                 act_ready
);
  // T of 0 or 1 both load 0, i.e. ready on the next cycle
  localparam logic [CNT_WIDTH-1:0] RCD_LD =
    (T_RCD > 1) ? CNT_WIDTH'(T_RCD - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] RAS_LD =
    (T_RAS > 1) ? CNT_WIDTH'(T_RAS - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] RP_LD =
    (T_RP > 1) ? CNT_WIDTH'(T_RP - 1) : '0;

  logic [CNT_WIDTH-1:0] rcd, ras, rp;

  function automatic logic [CNT_WIDTH-1:0] dec(
    input logic [CNT_WIDTH-1:0] c
  );
    return (c == '0) ? c : c - CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      open <= 1'b0;
      row  <= '0;
      rcd  <= '0;
      ras  <= '0;
      rp   <= '0;
    end else begin
      rcd <= dec(rcd);
      ras <= dec(ras);
      rp  <= dec(rp);
      if (act) begin
        open <= 1'b1;
        row  <= row_in;
        rcd  <= RCD_LD;
        ras  <= RAS_LD;
      end
      if (pre) begin
        open <= 1'b0;
        rp   <= RP_LD;
      end
    end
  end

  assign rdwr_ready = open & (rcd == '0);
  assign pre_ready  = open & (ras == '0);
  assign act_ready  = ~open & (rp == '0);
endmodule

// File: rtl/bank_timing_tracker.sv
// Per-(rank,bank) open-row and timing tracker fed by every DDR command.
// Define BANK_TIMING_CHECK_EN to build the sticky protocol checker.
module bank_timing_tracker
  import bank_timing_pkg::*;
#(
  parameter int ROW_WIDTH  = 15,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH   = 1,
  parameter int CNT_WIDTH  = 6,
  parameter int T_RCD      = 6,
  parameter int T_RAS      = 15,
  parameter int T_RP       = 6
) (
  input logic clk,
  input logic rst,
  bank_timing_if.slave bus
);
  localparam int NB     = 2**BANK_WIDTH;
  localparam int NT     = CS_WIDTH * NB;
  localparam int RANK_W = (CS_WIDTH > 1) ? $clog2(CS_WIDTH) : 1;
  localparam int QW     = RANK_W + BANK_WIDTH;

  logic                  vld, is_act, is_pre, prea;
  logic [2:0]            op;
  logic [CS_WIDTH-1:0]   rank_sel;
  logic [BANK_WIDTH-1:0] bank;
  logic [ROW_WIDTH-1:0]  row;

  logic [NT-1:0]        open_v, rdwr_v, pre_v, act_v;
  logic [ROW_WIDTH-1:0] row_v [NT];

  assign vld = (bus.is_app | bus.is_mnt) & bus.instr[VALID_BIT];
  assign op = {bus.instr[RAS_BIT], bus.instr[CAS_BIT],
               bus.instr[WE_BIT]};
  assign is_act = vld & (op == OP_ACT);
  assign is_pre = vld & (op == OP_PRE);
  assign prea = bus.instr[A10_BIT];
  assign rank_sel = ~bus.instr[CS_OFFSET +: CS_WIDTH];
  assign bank = bus.instr[ROW_WIDTH +: BANK_WIDTH];
  assign row = bus.instr[ROW_WIDTH-1:0];

`ifdef BANK_TIMING_CHECK_EN
  logic [NT-1:0] hit_v, sel_v;
`endif

  for (genvar r = 0; r < CS_WIDTH; r++) begin : g_rank
    for (genvar b = 0; b < NB; b++) begin : g_bank
      localparam int I = r * NB + b;
      logic hit, pre_b;
      assign hit = rank_sel[r] & (bank == BANK_WIDTH'(b));
      // PREA only reloads tRP on banks that were open
      assign pre_b = is_pre & rank_sel[r] &
                     (prea ? open_v[I] : (bank == BANK_WIDTH'(b)));
`ifdef BANK_TIMING_CHECK_EN
      assign hit_v[I] = hit;
      assign sel_v[I] = rank_sel[r];
`endif
      bank_timer #(
        .ROW_WIDTH(ROW_WIDTH), .CNT_WIDTH(CNT_WIDTH),
        .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP)
      ) u_bank (
        .clk(clk), .rst(rst),
        .act(is_act & hit), .pre(pre_b), .row_in(row),
        .open(open_v[I]), .row(row_v[I]),
        .rdwr_ready(rdwr_v[I]), .pre_ready(pre_v[I]),
        .act_ready(act_v[I])
      );
    end
    assign bus.any_open[r] = |open_v[r*NB +: NB];
  end

  logic [QW-1:0] q_idx;
  assign q_idx = {bus.q_rank, bus.q_bank};

  always_comb begin
    bus.q_state      = '0;
    bus.q_rdwr_ready = 1'b0;
    bus.q_pre_ready  = 1'b0;
    bus.q_act_ready  = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (q_idx == QW'(i)) begin
        bus.q_state      = {open_v[i], row_v[i]};
        bus.q_rdwr_ready = rdwr_v[i];
        bus.q_pre_ready  = pre_v[i];
        bus.q_act_ready  = act_v[i];
      end
    end
  end

`ifdef BANK_TIMING_CHECK_EN
  logic      is_rdwr, is_ref, err_q;
  err_code_e viol, code_q;

  assign is_rdwr = vld & (op[2:1] == OP_RDWR);
  assign is_ref  = vld & (op == OP_REF);

  always_comb begin
    viol = ERR_NONE;
    unique case (1'b1)
      is_act & |(hit_v & ~act_v):
        viol = ERR_ACT;
      (is_pre & ~prea & |(hit_v & open_v & ~pre_v)) |
      (is_rdwr & |(hit_v & ~rdwr_v)):
        viol = ERR_ACCESS;
      is_ref & |(sel_v & open_v):
        viol = ERR_REF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else if (!err_q && viol != ERR_NONE) begin
      err_q  <= 1'b1;
      code_q <= viol;
    end
  end

  assign bus.err      = err_q;
  assign bus.err_code = code_q;
`else
  assign bus.err      = 1'b0;
  assign bus.err_code = 2'd0;
`endif
endmodule

// File: tb/tb_bank_timing_tracker.sv
// Scoreboard bench for bank_timing_tracker with two ranks.
module tb_bank_timing_tracker;
  import bank_timing_pkg::*;

  typedef enum {
    F_STATE, F_RDWR, F_PRE, F_ACT, F_ANY, F_ERR, F_CODE
  } fld_e;

  typedef struct {
    string       name;
    fld_e        f;
    logic [31:0] v;
  } exp_t;

`ifdef BANK_TIMING_CHECK_EN
  localparam logic [31:0] E_ERR  = 32'd1;
  localparam logic [31:0] E_CODE = 32'd2;
`else
  localparam logic [31:0] E_ERR  = 32'd0;
  localparam logic [31:0] E_CODE = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  bank_timing_if #(
    .ROW_WIDTH(15), .BANK_WIDTH(3), .CS_WIDTH(2)
  ) bus ();

  bank_timing_tracker #(.CS_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] got;
      e = sbq.pop_front();
      case (e.f)
        F_STATE: got = 32'(bus.q_state);
        F_RDWR:  got = 32'(bus.q_rdwr_ready);
        F_PRE:   got = 32'(bus.q_pre_ready);
        F_ACT:   got = 32'(bus.q_act_ready);
        F_ANY:   got = 32'(bus.any_open);
        F_ERR:   got = 32'(bus.err);
        default: got = 32'(bus.err_code);
      endcase
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h",
                 e.name, got, e.v);
      end
    end
  end

  function automatic logic [31:0] mk(
    input logic [2:0] op, input logic [1:0] cs,
    input int bank, input int row
  );
    logic [31:0] w;
    w = '0;
    w[31] = 1'b1;
    w[30:28] = op;
    w[25:24] = cs;
    w[17:15] = bank[2:0];
    w[14:0] = row[14:0];
    return w;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
    bus.instr = '0;
    bus.is_app = 1'b0;
    bus.is_mnt = 1'b0;
  endtask

  task automatic nxt_n(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic cmd(
    input logic [2:0] op, input logic [1:0] cs,
    input int bank, input int row, input bit app
  );
    bus.instr = mk(op, cs, bank, row);
    bus.is_app = app;
    bus.is_mnt = ~app;
  endtask

  task automatic qry(input int r, input int b);
    bus.q_rank = r[0];
    bus.q_bank = b[2:0];
  endtask

  task automatic ex(
    input string n, input fld_e f, input logic [31:0] v
  );
    exp_t e;
    e.name = n;
    e.f = f;
    e.v = v;
    sbq.push_back(e);
  endtask

  initial begin
    bus.instr = '0;
    bus.is_app = 1'b0;
    bus.is_mnt = 1'b0;
    qry(0, 3);
    #1;
    // ACT while in reset must be dropped
    cmd(OP_ACT, 2'b10, 3, 'h55, 1'b1);
    nxt();
    nxt();
    rst = 1'b0;
    // C0
    ex("rst_state", F_STATE, 0);
    ex("rst_act", F_ACT, 1);
    ex("rst_rdwr", F_RDWR, 0);
    ex("rst_pre", F_PRE, 0);
    ex("rst_any", F_ANY, 0);
    ex("rst_err", F_ERR, 0);
    ex("rst_code", F_CODE, 0);
    nxt();
    // C1: ACT r0 b2, same-cycle query sees old state
    cmd(OP_ACT, 2'b10, 2, 'h1A5, 1'b1);
    qry(0, 2);
    ex("act_same_cyc", F_STATE, 0);
    nxt();
    // C2
    ex("act_state", F_STATE, 'h81A5);
    ex("act_rdwr_early", F_RDWR, 0);
    ex("act_actrdy", F_ACT, 0);
    ex("act_any", F_ANY, 'b01);
    nxt_n(4);
    // C6 / C7: tRCD edge
    ex("rcd_minus1", F_RDWR, 0);
    nxt();
    ex("rcd_edge", F_RDWR, 1);
    ex("ras_early", F_PRE, 0);
    nxt_n(8);
    // C15 / C16: tRAS edge, then PRE
    ex("ras_minus1", F_PRE, 0);
    nxt();
    ex("ras_edge", F_PRE, 1);
    cmd(OP_PRE, 2'b10, 2, 0, 1'b1);
    nxt();
    // C17
    ex("pre_state", F_STATE, 'h01A5);
    ex("pre_actrdy", F_ACT, 0);
    ex("pre_rdwr", F_RDWR, 0);
    ex("pre_any", F_ANY, 0);
    nxt_n(4);
    // C21 / C22: tRP edge
    ex("rp_minus1", F_ACT, 0);
    nxt();
    ex("rp_edge", F_ACT, 1);
    nxt();
    // C23/C24: invalid commands
    bus.instr = mk(OP_ACT, 2'b10, 4, 'h123);
    qry(0, 4);
    nxt();
    bus.instr = mk(OP_ACT, 2'b10, 4, 'h123);
    bus.instr[31] = 1'b0;
    bus.is_mnt = 1'b1;
    nxt();
    // C25
    ex("inval_state", F_STATE, 0);
    ex("inval_act", F_ACT, 1);
    nxt();
    // C26/C27: open one bank on each rank
    cmd(OP_ACT, 2'b10, 1, 'h0011, 1'b1);
    nxt();
    cmd(OP_ACT, 2'b01, 5, 'h7FFF, 1'b0);
    qry(1, 5);
    nxt();
    // C28: PREA on rank0 only
    ex("r1_state", F_STATE, 'hFFFF);
    ex("two_open", F_ANY, 'b11);
    cmd(OP_PRE, 2'b10, 0, 'h400, 1'b0);
    nxt();
    // C29
    qry(0, 1);
    ex("prea_r0_state", F_STATE, 'h0011);
    ex("prea_r0_act", F_ACT, 0);
    ex("prea_any", F_ANY, 'b10);
    nxt();
    // C30
    qry(1, 5);
    ex("prea_r1_state", F_STATE, 'hFFFF);
    ex("prea_r1_rdwr", F_RDWR, 0);
    nxt();
    // C31: closed bank keeps its expired tRP
    qry(0, 2);
    ex("prea_closed_act", F_ACT, 1);
    ex("prea_closed_row", F_STATE, 'h01A5);
    ex("no_err_yet", F_ERR, 0);
    nxt();
    // C32..C34: ACT b0, early PRE
    cmd(OP_ACT, 2'b10, 0, 'h0042, 1'b1);
    nxt();
    nxt();
    cmd(OP_PRE, 2'b10, 0, 0, 1'b1);
    qry(0, 0);
    ex("early_pre_state", F_STATE, 'h8042);
    ex("early_pre_ras", F_PRE, 0);
    nxt();
    // C35
    ex("early_pre_err", F_ERR, E_ERR);
    ex("early_pre_code", F_CODE, E_CODE);
    ex("early_pre_closed", F_STATE, 'h0042);
    nxt_n(5);
    // C40: re-open b0, then REF and early RD
    ex("reopen_ready", F_ACT, 1);
    cmd(OP_ACT, 2'b10, 0, 'h0042, 1'b1);
    nxt();
    cmd(OP_REF, 2'b10, 0, 0, 1'b0);
    ex("ref_state", F_STATE, 'h8042);
    ex("ref_any", F_ANY, 'b11);
    nxt();
    // C42
    ex("ref_err", F_ERR, E_ERR);
    ex("ref_code_kept", F_CODE, E_CODE);
    cmd(3'b100, 2'b10, 0, 0, 1'b1);
    nxt();
    // C43
    ex("rd_state", F_STATE, 'h8042);
    ex("rd_code_kept", F_CODE, E_CODE);
    nxt();
    @(negedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
